// File: rtl/shader_loader_pkg.sv
// Shared definitions for the shader loader: host command bytes, FSM states
// and the status value reported when a run is abandoned.
package shader_loader_pkg;

  localparam logic [7:0] CMD_WRITE_INST = 8'h01;
  localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
  localparam logic [7:0] CMD_RUN        = 8'h03;

  localparam logic [31:0] TIMEOUT_REPORT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_CMD,
    ST_ADDR0,
    ST_ADDR1,
    ST_CNT0,
    ST_CNT1,
    ST_WORD,
    ST_CORE_RESET,
    ST_RUN,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/le_word_assembler.sv
// Little-endian byte-to-word assembler. The first three bytes of a word are
// shifted in; the fourth is combined combinationally so the completed word
// is available in the same cycle the last byte is accepted (word_done).
module le_word_assembler (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] low_bytes;
  logic [1:0]  byte_index;

  // Shift bytes in from the top so byte 0 ends up in the low lane.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      low_bytes  <= '0;
      byte_index <= '0;
    end else if (byte_valid) begin
      low_bytes  <= {byte_in, low_bytes[23:8]};
      byte_index <= byte_index + 2'd1;
    end
  end

  // Completed word and pulse on the fourth accepted byte.
  always_comb begin
    word      = {byte_in, low_bytes};
    word_done = byte_valid && (byte_index == 2'd3);
  end

endmodule

// File: rtl/shader_loader.sv
// Host-side command front end for the GPU core: loads instruction/data
// words through the core's external write port, runs the core and reports
// the cycle count of the run as four little-endian status bytes.
//
// state        | meaning
// ST_CMD       | waiting for a command byte
// ST_ADDR0/1   | base address low/high byte
// ST_CNT0/1    | word count low/high byte
// ST_WORD      | collecting word bytes, strobing each completed word
// ST_CORE_RESET| core held in reset for one cycle
// ST_RUN       | core running, cycles counted
// ST_REPORT    | returning the 32-bit result, LSB first
module shader_loader
  import shader_loader_pkg::*;
#(
  parameter int          ADDRESS_WIDTH  = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     core_reset_n,
  output logic                     core_run,
  input  logic                     core_halted,
  output logic [ADDRESS_WIDTH-1:0] ext_write_address,
  output logic [31:0]              ext_write_data,
  output logic                     ext_enable_write_inst,
  output logic                     ext_enable_write_data,
  output logic                     bad_command,
  output logic                     timed_out
);

  state_t      state, state_next;
  logic [15:0] next_address;
  logic [15:0] words_left;
  logic        write_to_data;
  logic [31:0] run_count;
  logic [31:0] run_count_inc;
  logic        run_timeout;
  logic [31:0] result;
  logic [1:0]  report_idx;
  logic        accept;
  logic        strobe;
  logic        input_phase;
  logic [31:0] word;
  logic        word_done;
  logic        known_command;

  le_word_assembler u_assembler (
    .clock      (clock),
    .reset_n    (reset_n),
    .byte_valid (accept && (state == ST_WORD)),
    .byte_in    (in_data),
    .word       (word),
    .word_done  (word_done)
  );

  // Handshake qualifiers; input is blocked during the write strobe and
  // until the loader has come out of reset.
  always_comb begin
    strobe        = ext_enable_write_inst || ext_enable_write_data;
    input_phase   = (state == ST_CMD) || (state == ST_ADDR0) || (state == ST_ADDR1) ||
                    (state == ST_CNT0) || (state == ST_CNT1) || (state == ST_WORD);
    in_ready      = core_reset_n && input_phase && !strobe;
    accept        = in_valid && in_ready;
    known_command = (in_data == CMD_WRITE_INST) || (in_data == CMD_WRITE_DATA) ||
                    (in_data == CMD_RUN);
    run_count_inc = (run_count == 32'hFFFF_FFFF) ? run_count : run_count + 32'd1;
    run_timeout   = (run_count_inc == TIMEOUT_CYCLES);
    out_valid     = (state == ST_REPORT);
    out_data      = (state == ST_REPORT) ? result[{report_idx, 3'b000} +: 8] : 8'h00;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_CMD;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_CMD: begin
        if (accept) begin
          if ((in_data == CMD_WRITE_INST) || (in_data == CMD_WRITE_DATA)) state_next = ST_ADDR0;
          else if (in_data == CMD_RUN)                                     state_next = ST_CORE_RESET;
        end
      end
      ST_ADDR0: if (accept) state_next = ST_ADDR1;
      ST_ADDR1: if (accept) state_next = ST_CNT0;
      ST_CNT0:  if (accept) state_next = ST_CNT1;
      ST_CNT1: begin
        if (accept) state_next = ({in_data, words_left[7:0]} == 16'd0) ? ST_CMD : ST_WORD;
      end
      ST_WORD:       if (word_done && (words_left == 16'd1)) state_next = ST_CMD;
      ST_CORE_RESET: state_next = ST_RUN;
      ST_RUN:        if (core_halted || run_timeout) state_next = ST_REPORT;
      ST_REPORT:     if (out_ready && (report_idx == 2'd3)) state_next = ST_CMD;
      default:       state_next = ST_CMD;
    endcase
  end

  // Packet header capture, address stepping and the one-cycle write strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      next_address          <= '0;
      words_left            <= '0;
      write_to_data         <= 1'b0;
      ext_write_address     <= '0;
      ext_write_data        <= '0;
      ext_enable_write_inst <= 1'b0;
      ext_enable_write_data <= 1'b0;
    end else begin
      ext_enable_write_inst <= 1'b0;
      ext_enable_write_data <= 1'b0;
      if (accept) begin
        case (state)
          ST_CMD:   write_to_data <= (in_data == CMD_WRITE_DATA);
          ST_ADDR0: next_address[7:0]  <= in_data;
          ST_ADDR1: next_address[15:8] <= in_data;
          ST_CNT0:  words_left[7:0]    <= in_data;
          ST_CNT1:  words_left[15:8]   <= in_data;
          default:  ;
        endcase
      end
      if (word_done) begin
        ext_write_address     <= ADDRESS_WIDTH'(next_address);
        ext_write_data        <= word;
        ext_enable_write_inst <= !write_to_data;
        ext_enable_write_data <= write_to_data;
        next_address          <= next_address + 16'd4;
        words_left            <= words_left - 16'd1;
      end
    end
  end

  // Run cycle counter, result latch and report byte index.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      run_count  <= '0;
      result     <= '0;
      report_idx <= '0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        ST_CORE_RESET: begin
          run_count  <= '0;
          report_idx <= '0;
        end
        ST_RUN: begin
          if (core_halted) begin
            result    <= run_count;
            timed_out <= 1'b0;
          end else begin
            run_count <= run_count_inc;
            if (run_timeout) begin
              result    <= TIMEOUT_REPORT;
              timed_out <= 1'b1;
            end
          end
        end
        ST_REPORT: if (out_ready) report_idx <= report_idx + 2'd1;
        default: ;
      endcase
    end
  end

  // Core control lines and the sticky bad-command flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      core_reset_n <= 1'b0;
      core_run     <= 1'b0;
      bad_command  <= 1'b0;
    end else begin
      core_reset_n <= (state_next != ST_CORE_RESET);
      core_run     <= (state_next == ST_RUN);
      if (accept && (state == ST_CMD) && !known_command) bad_command <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shader_loader.sv
// Self-checking bench for shader_loader: randomized packets with host stalls,
// a queue of expected writes built from the packet rules, and a small core
// model that halts a chosen number of cycles after run rises.
module tb_shader_loader;

  localparam logic [31:0] TIMEOUT = 32'd100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        core_reset_n;
  logic        core_run;
  logic        core_halted;
  logic [15:0] ext_write_address;
  logic [31:0] ext_write_data;
  logic        ext_enable_write_inst;
  logic        ext_enable_write_data;
  logic        bad_command;
  logic        timed_out;

  shader_loader #(.ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .core_reset_n          (core_reset_n),
    .core_run              (core_run),
    .core_halted           (core_halted),
    .ext_write_address     (ext_write_address),
    .ext_write_data        (ext_write_data),
    .ext_enable_write_inst (ext_enable_write_inst),
    .ext_enable_write_data (ext_enable_write_data),
    .bad_command           (bad_command),
    .timed_out             (timed_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected write port traffic.
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        inst;
  } wr_t;
  wr_t exp_q[$];
  wr_t wr_mon;

  always @(negedge clock) begin
    if (reset_n && (ext_enable_write_inst || ext_enable_write_data)) begin
      check("strobe_one_hot", 32'(ext_enable_write_inst & ext_enable_write_data), 0);
      check("in_ready_in_strobe", 32'(in_ready), 0);
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        wr_mon = exp_q.pop_front();
        check("write_addr", 32'(ext_write_address), 32'(wr_mon.addr));
        check("write_data", ext_write_data, wr_mon.data);
        check("write_is_inst", 32'(ext_enable_write_inst), 32'(wr_mon.inst));
      end
    end
  end

  // Core model: halted rises halt_delay cycles after run first goes high.
  int unsigned age = 0;
  logic        halt_en = 1'b0;
  int unsigned halt_delay = 0;
  always @(posedge clock) begin
    if (!core_reset_n) age <= 0;
    else if (core_run) age <= age + 1;
  end
  assign core_halted = halt_en && (age >= halt_delay);

  int   run_hi = 0;
  int   rst_pulses = 0;
  logic prev_crn = 1'b0;
  always @(negedge clock) begin
    if (core_run) run_hi++;
    if (prev_crn && !core_reset_n) rst_pulses++;
    prev_crn = core_reset_n;
  end

  logic [31:0] wbuf [16];

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b0;
    idle($urandom_range(0, 2));
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    check("byte_accepted", 32'(ok), 1);
  endtask

  task automatic send_write(input logic inst, input logic [15:0] base, input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = base + 16'(4 * k);
      e.data = wbuf[k];
      e.inst = inst;
      exp_q.push_back(e);
    end
    send_byte(inst ? 8'h01 : 8'h02);
    send_byte(base[7:0]);
    send_byte(base[15:8]);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) send_byte(8'(wbuf[k] >> (8 * j)));
  endtask

  task automatic wait_writes();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    check("writes_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic random_write(input logic inst, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) wbuf[k] = $urandom;
    send_write(inst, base, n);
    wait_writes();
  endtask

  task automatic do_run(input logic en, input int unsigned delay);
    logic [31:0] got;
    logic [31:0] expected;
    int k;
    halt_en    = en;
    halt_delay = delay;
    expected   = (en && delay < TIMEOUT) ? 32'(delay) : 32'hFFFF_FFFF;
    run_hi     = 0;
    rst_pulses = 0;
    send_byte(8'h03);
    got = '0;
    k = 0;
    for (int i = 0; i < 3000 && k < 4; i++) begin
      @(posedge clock);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (out_valid && out_ready) begin
        got[8*k +: 8] = out_data;
        k++;
      end
    end
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("reply_bytes", 32'(k), 4);
    check("reply_value", got, expected);
    check("timed_out", 32'(timed_out), 32'(expected == 32'hFFFF_FFFF));
    check("core_reset_pulses", 32'(rst_pulses), 1);
    if (!en) check("timeout_run_cycles", 32'(run_hi), TIMEOUT);
    @(negedge clock);
    check("out_valid_after_reply", 32'(out_valid), 0);
    idle(1);
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_core_reset_n", 32'(core_reset_n), 0);
    check("rst_core_run", 32'(core_run), 0);
    check("rst_we_inst", 32'(ext_enable_write_inst), 0);
    check("rst_we_data", 32'(ext_enable_write_data), 0);
    check("rst_addr", 32'(ext_write_address), 0);
    check("rst_data", ext_write_data, 0);
    check("rst_bad_command", 32'(bad_command), 0);
    check("rst_timed_out", 32'(timed_out), 0);
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    @(negedge clock);
    check("crn_low_at_release", 32'(core_reset_n), 0);
    @(negedge clock);
    check("crn_high_after_release", 32'(core_reset_n), 1);
    check("in_ready_after_release", 32'(in_ready), 1);
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle(3);
    check_reset_state();
    release_reset();

    wbuf[0] = 32'h0000_0013;
    wbuf[1] = 32'h0010_0073;
    send_write(1'b1, 16'h0010, 2);
    wait_writes();

    random_write(1'b0, 16'hFFFC, 2);

    send_write(1'b1, 16'h1234, 0);
    random_write(1'b0, 16'h0200, 1);

    check("bad_command_clear", 32'(bad_command), 0);
    send_byte(8'h7E);
    random_write(1'b0, 16'h0040, 2);
    check("bad_command_set", 32'(bad_command), 1);

    for (int p = 0; p < 6; p++)
      random_write(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 4));

    do_run(1'b1, 37);
    do_run(1'b1, $urandom_range(1, 60));
    do_run(1'b0, 0);
    do_run(1'b1, $urandom_range(1, 60));
    check("bad_command_sticky", 32'(bad_command), 1);

    // Reset in the middle of a word.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset_n = 1'b0;
    idle(2);
    check_reset_state();
    release_reset();
    random_write(1'b1, 16'h0100, 2);

    // Reset in the middle of a run.
    halt_en = 1'b0;
    send_byte(8'h03);
    idle(20);
    check("core_run_mid_run", 32'(core_run), 1);
    reset_n = 1'b0;
    idle(2);
    check_reset_state();
    release_reset();
    random_write(1'b1, 16'h0300, 1);
    do_run(1'b1, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shader_loader.md
# shader_loader

Host-side front end for the GPU core. Parses an 8-bit valid/ready command stream from the host link and writes program words into instruction RAM or data RAM through the core's external write port while the core is stopped. On command it resets and starts the core, waits for `halted`, and returns the run's cycle count as a 4-byte status reply. Sits directly upstream of the core and drives its `reset_n`, `run` and `ext_*` write inputs.

## Interface
- `ADDRESS_WIDTH`, 16, width of `ext_write_address`.
- `TIMEOUT_CYCLES`, 32'd1_000_000, run cycles before the core is abandoned.
- `clock`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  host byte available.
- `in_ready`  out  1  loader accepts byte; transfer when `in_valid && in_ready`.
- `in_data`  in  8  host byte.
- `out_valid`  out  1  status byte available.
- `out_ready`  in  1  host accepts status byte.
- `out_data`  out  8  status byte.
- `core_reset_n`  out  1  to core `reset_n`.
- `core_run`  out  1  to core `run`.
- `core_halted`  in  1  from core `halted`.
- `ext_write_address`  out  16  to core.
- `ext_write_data`  out  32  to core.
- `ext_enable_write_inst`  out  1  to core.
- `ext_enable_write_data`  out  1  to core.
- `bad_command`  out  1  sticky: unknown command byte seen.
- `timed_out`  out  1  sticky: last run hit `TIMEOUT_CYCLES`.

## Operation
- Command bytes: 0x01 WRITE_INST, 0x02 WRITE_DATA, 0x03 RUN. Any other byte: set `bad_command`, discard byte, stay in CMD.
- WRITE_*: next 2 bytes = base address (LE), next 2 bytes = word count N (LE), then 4·N data bytes, each word LE. Word k is written at `base + 4k`, modulo 2^16 (wraps). N = 0: return to CMD after count bytes.
- RUN: CORE_RESET (`core_reset_n`=0, `core_run`=0, one cycle) → RUN (`core_run`=1, cycle counter cleared then incremented each RUN cycle) → on `core_halted`=1 or counter == `TIMEOUT_CYCLES`: drop `core_run`, go to REPORT. Timeout reports 32'hFFFF_FFFF and sets `timed_out`; normal halt reports count and clears `timed_out`.
- REPORT: 4 bytes of the 32-bit result, LSB first, one per `out_valid && out_ready` handshake; then CMD.
- States: CMD, ADDR0, ADDR1, CNT0, CNT1, WORD (byte index 0–3), CORE_RESET, RUN, REPORT (byte index 0–3).
- `in_ready`=1 only in CMD/ADDR*/CNT*/WORD, and 0 in the cycle a write strobe is asserted. `out_valid`=1 only in REPORT.
- `bad_command` clears only on reset.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `core_reset_n`=0, `core_run`=0, both write enables 0, address/data 0, `bad_command`=0, `timed_out`=0, state CMD. `core_reset_n` goes 1 on the first cycle after `reset_n` releases; `in_ready` rises the same cycle.
- Write strobe: the cycle after the 4th byte of a word is accepted, exactly one of `ext_enable_write_inst`/`_data` is high for one cycle, with address and data stable in that cycle. The core samples them one cycle later, so address and data hold until the next strobe.
- Back-to-back words: at most one strobe every 5 cycles (4 bytes plus the strobe cycle).
- RUN command byte accepted at cycle t → `core_reset_n`=0 at t+1 → `core_run`=1 from t+2. Counter counts cycles with `core_run`=1 before `core_halted` is seen, saturating at 2^32−1.
- Host stalls (`in_valid`=0) mid-packet hold all state; there is no timeout on the input side.
- `core_halted` high during CORE_RESET is ignored because it is stale from the previous run.
- Loader reset mid-packet or mid-run: the partial word is dropped, `core_run`=0, `core_reset_n`=0 for the reset duration, and the FSM restarts in CMD.

## Structure
- Package `shader_loader_pkg`: command constants (CMD_WRITE_INST/DATA/RUN), state enum, reported timeout value 32'hFFFF_FFFF.
- Sub-module `le_word_assembler`: 4-byte little-endian shift-in with byte index and `word_done` pulse. The FSM, address counter, cycle counter and report serializer stay in `shader_loader`.

## Test plan
- WRITE_INST base 0x0010, N=2, words 0x00000013 and 0x00100073 → strobes at address 0x0010 then 0x0014 with matching data; `ext_enable_write_data` stays 0.
- WRITE_DATA base 0xFFFC, N=2 → writes at 0xFFFC then 0x0000 (wrap). N=0 packet → no strobe, next command accepted.
- Byte 0x7E followed by valid WRITE_DATA → `bad_command`=1 and the write still completes correctly.
- RUN with a core model that raises halted 37 cycles after `core_run` rises → one `core_reset_n` low pulse; reply bytes 0x25,0x00,0x00,0x00 with `out_ready` toggling randomly.
- RUN with halted never asserted, `TIMEOUT_CYCLES`=100 → `core_run` drops after 100 cycles; reply FF FF FF FF; `timed_out`=1.
- `reset_n` asserted mid-word and mid-RUN → outputs return to reset values; a fresh WRITE_INST afterwards writes correctly.
